// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot loader:
// frame target codes, FSM states and target decode.
package prog_loader_pkg;

  localparam logic [7:0] LDR_TGT_IMEM = 8'h00;
  localparam logic [7:0] LDR_TGT_DMEM = 8'h01;
  localparam logic [7:0] LDR_TGT_RUN  = 8'h02;

  localparam int LDR_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_LOAD,
    ST_DRAIN,
    ST_RUN
  } ldr_state_e;

  typedef enum logic [1:0] {
    TGT_IMEM,
    TGT_DMEM,
    TGT_RUN,
    TGT_BAD
  } ldr_tgt_e;

  function automatic ldr_tgt_e ldr_decode(
    input logic [7:0] b
  );
    ldr_tgt_e t;
    t = TGT_BAD;
    unique case (1'b1)
      (b == LDR_TGT_IMEM): t = TGT_IMEM;
      (b == LDR_TGT_DMEM): t = TGT_DMEM;
      (b == LDR_TGT_RUN):  t = TGT_RUN;
      default:             t = TGT_BAD;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs a byte stream into little-endian words;
// word_valid_o fires with the byte that fills the last lane.
module word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_i,
  input  logic                  strobe_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_valid_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LW-1:0]         lane_q;
  logic [DATA_WIDTH-1:0] sr_q;
  logic                  last;

  assign last = (lane_q == LW'(LANES - 1));
  assign word_valid_o = strobe_i & last;

  // Completed word is visible in the same cycle as its final byte
  always_comb begin
    word_o = sr_q;
    word_o[lane_q*8 +: 8] = byte_i;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      lane_q <= '0;
      sr_q   <= '0;
    end else if (strobe_i) begin
      sr_q[lane_q*8 +: 8] <= byte_i;
      lane_q <= last ? '0 : lane_q + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream boot loader: fills IMEM/DMEM
// through their write ports, then releases the core.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_WIDTH = LDR_DATA_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  cpu_stall,
  output logic                  init_done,
  output logic                  busy,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  words_written
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SH    = $clog2(BYTES);

  ldr_state_e state_q, state_d;
  ldr_tgt_e   tgt_q;

  logic [7:0]            cnt_lo_q;
  logic [CNT_WIDTH-1:0]  n_q;
  logic [CNT_WIDTH-1:0]  idx_q;
  logic [CNT_WIDTH-1:0]  n_hdr;
  logic [15:0]           hdr;
  logic [ADDR_WIDTH-1:0] addr;

  logic                  in_ready_q;
  logic                  cpu_stall_q;
  logic                  init_done_q;
  logic                  busy_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  ww_q;
  logic [ADDR_WIDTH-1:0] i_w_addr_q, d_w_addr_q;
  logic [DATA_WIDTH-1:0] i_w_dat_q, d_w_dat_q;
  logic                  i_w_enb_q, d_w_enb_q;

  logic                  hs;
  logic                  in_body;
  logic                  strb;
  logic                  clr;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  asm_wv;
  logic                  last_word;
  logic                  over;

  assign hs      = in_valid & in_ready_q;
  assign in_body = (state_q == ST_LOAD) ||
                   (state_q == ST_DRAIN);
  assign strb    = hs & in_body;
  assign clr     = ~in_body;

  assign hdr   = {in_byte, cnt_lo_q};
  assign n_hdr = CNT_WIDTH'(hdr);
  assign last_word = (idx_q == n_q - 1'b1);
  assign addr  = ADDR_WIDTH'(idx_q) << SH;

  always_comb begin
    over = 1'b0;
    if (tgt_q == TGT_IMEM)
      over = 32'(n_hdr) > 32'(IMEM_WORDS);
    else if (tgt_q == TGT_DMEM)
      over = 32'(n_hdr) > 32'(DMEM_WORDS);
  end

  word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (in_byte),
    .strobe_i     (strb),
    .clear_i      (clr),
    .word_o       (asm_word),
    .word_valid_o (asm_wv)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (hs) state_d = ST_CNT_LO;
      ST_CNT_LO: if (hs) state_d = ST_CNT_HI;
      ST_CNT_HI: begin
        if (hs) begin
          if (tgt_q == TGT_RUN)
            state_d = ST_RUN;
          else if (tgt_q == TGT_BAD)
            state_d = ST_IDLE;
          else if (n_hdr == '0)
            state_d = ST_IDLE;
          else if (over)
            state_d = ST_DRAIN;
          else
            state_d = ST_LOAD;
        end
      end
      ST_LOAD, ST_DRAIN:
        if (asm_wv && last_word) state_d = ST_IDLE;
      ST_RUN:    state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tgt_q       <= TGT_BAD;
      cnt_lo_q    <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      cpu_stall_q <= 1'b1;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ww_q        <= '0;
      i_w_addr_q  <= '0;
      i_w_dat_q   <= '0;
      i_w_enb_q   <= 1'b0;
      d_w_addr_q  <= '0;
      d_w_dat_q   <= '0;
      d_w_enb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_RUN);
      cpu_stall_q <= (state_d != ST_RUN);
      init_done_q <= (state_d == ST_RUN);
      busy_q      <= (state_d != ST_IDLE) &&
                     (state_d != ST_RUN);
      i_w_enb_q   <= 1'b0;
      d_w_enb_q   <= 1'b0;

      if (hs && state_q == ST_IDLE)
        tgt_q <= ldr_decode(in_byte);
      if (hs && state_q == ST_CNT_LO)
        cnt_lo_q <= in_byte;
      if (hs && state_q == ST_CNT_HI) begin
        n_q   <= n_hdr;
        idx_q <= '0;
        if (tgt_q == TGT_BAD || over)
          err_q <= 1'b1;
      end

      // Drained words advance the index but never write
      if (asm_wv) begin
        idx_q <= idx_q + 1'b1;
        if (state_q == ST_LOAD) begin
          ww_q <= ww_q + 1'b1;
          if (tgt_q == TGT_IMEM) begin
            i_w_enb_q  <= 1'b1;
            i_w_addr_q <= addr;
            i_w_dat_q  <= asm_word;
          end else begin
            d_w_enb_q  <= 1'b1;
            d_w_addr_q <= addr;
            d_w_dat_q  <= asm_word;
          end
        end
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign cpu_stall     = cpu_stall_q;
  assign init_done     = init_done_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign words_written = ww_q;
  assign i_w_addr      = i_w_addr_q;
  assign i_w_dat       = i_w_dat_q;
  assign i_w_enb       = i_w_enb_q;
  assign d_w_addr      = d_w_addr_q;
  assign d_w_dat       = d_w_dat_q;
  assign d_w_enb       = d_w_enb_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected BRAM
// writes are queued by stimulus, popped by a monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic        i_w_enb, d_w_enb;
  logic        cpu_stall, init_done, busy, err;
  logic [15:0] words_written;

  typedef struct packed {
    logic        dmem;
    logic [9:0]  addr;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  gaps  = 1'b0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk           (clk),
    .rst           (rst),
    .in_byte       (in_byte),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .i_w_addr      (i_w_addr),
    .i_w_dat       (i_w_dat),
    .i_w_enb       (i_w_enb),
    .d_w_addr      (d_w_addr),
    .d_w_dat       (d_w_dat),
    .d_w_enb       (d_w_enb),
    .cpu_stall     (cpu_stall),
    .init_done     (init_done),
    .busy          (busy),
    .err           (err),
    .words_written (words_written)
  );

  // Monitor: every cycle with a write pulse consumes one entry
  always @(negedge clk) begin
    wr_t a, e;
    if (i_w_enb || d_w_enb) begin
      n_cmp++;
      a.dmem = d_w_enb;
      a.addr = d_w_enb ? d_w_addr : i_w_addr;
      a.dat  = d_w_enb ? d_w_dat : i_w_dat;
      if (i_w_enb && d_w_enb) begin
        n_bad++;
        $display("FAIL wr_both: i_w_enb and d_w_enb high, required one");
      end else if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got dmem=%0d addr=%0h dat=%08h, required no write",
                 a.dmem, a.addr, a.dat);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL wr_data: got dmem=%0d addr=%0h dat=%08h, required dmem=%0d addr=%0h dat=%08h",
                   a.dmem, a.addr, a.dat, e.dmem, e.addr, e.dat);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h",
               nm, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    if (gaps && $urandom_range(1) == 1) begin
      in_valid = 1'b0;
      idle($urandom_range(1, 3));
    end
    in_byte  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      idle(1);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready=0, required 1");
      in_valid = 1'b0;
      return;
    end
    idle(1);
    in_valid = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] tgt,
                     input logic [15:0] n);
    send(tgt);
    send(n[7:0]);
    send(n[15:8]);
  endtask

  task automatic word(input logic dm,
                      input logic [9:0] ad,
                      input logic [31:0] w);
    wr_t e;
    e.dmem = dm;
    e.addr = ad;
    e.dat  = w;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_i_enb"}, 32'(i_w_enb), 0);
    chk({tag, "_i_addr"}, 32'(i_w_addr), 0);
    chk({tag, "_i_dat"}, i_w_dat, 0);
    chk({tag, "_d_enb"}, 32'(d_w_enb), 0);
    chk({tag, "_d_addr"}, 32'(d_w_addr), 0);
    chk({tag, "_d_dat"}, d_w_dat, 0);
    chk({tag, "_stall"}, 32'(cpu_stall), 1);
    chk({tag, "_done"}, 32'(init_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_ww"}, 32'(words_written), 0);
    chk({tag, "_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_byte = 8'h00;
    idle(2);
    rst = 1'b0;
    chk_reset("rst0");

    // IMEM two words, then RUN
    hdr(8'h00, 16'd2);
    word(1'b0, 10'h000, 32'h00100013);
    word(1'b0, 10'h004, 32'h00200093);
    idle(2);
    chk("t1_ww", 32'(words_written), 2);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_stall_pre", 32'(cpu_stall), 1);
    hdr(8'h02, 16'd0);
    idle(2);
    chk("t1_stall", 32'(cpu_stall), 0);
    chk("t1_done", 32'(init_done), 1);
    chk("t1_ready", 32'(in_ready), 0);
    chk("t1_busy_run", 32'(busy), 0);
    chk("t1_ww_run", 32'(words_written), 2);

    // DMEM three words
    do_reset();
    chk("t2_done_rst", 32'(init_done), 0);
    hdr(8'h01, 16'd3);
    word(1'b1, 10'h000, 32'h00000005);
    word(1'b1, 10'h004, 32'h00000001);
    word(1'b1, 10'h008, 32'h00000000);
    idle(2);
    chk("t2_err", 32'(err), 0);
    chk("t2_ww", 32'(words_written), 3);

    // Oversize DMEM frame drains silently
    hdr(8'h01, 16'd257);
    idle(1);
    chk("t3_err", 32'(err), 1);
    chk("t3_busy", 32'(busy), 1);
    for (int i = 0; i < 1028; i++) send(8'hA5);
    idle(2);
    chk("t3_idle", 32'(busy), 0);
    chk("t3_ww", 32'(words_written), 3);
    hdr(8'h00, 16'd1);
    word(1'b0, 10'h000, 32'h12345678);
    idle(2);
    chk("t3_ww2", 32'(words_written), 4);
    chk("t3_err2", 32'(err), 1);

    // Invalid target
    do_reset();
    hdr(8'h07, 16'd0);
    idle(1);
    chk("t4_err", 32'(err), 1);
    chk("t4_busy", 32'(busy), 0);
    hdr(8'h00, 16'd1);
    word(1'b0, 10'h000, 32'hDEADBEEF);
    idle(2);
    chk("t4_ww", 32'(words_written), 1);

    // Random in_valid gaps
    gaps = 1'b1;
    hdr(8'h00, 16'd4);
    word(1'b0, 10'h000, 32'h03020100);
    word(1'b0, 10'h004, 32'h07060504);
    word(1'b0, 10'h008, 32'h0B0A0908);
    word(1'b0, 10'h00C, 32'h0F0E0D0C);
    gaps = 1'b0;
    idle(2);
    chk("t5_ww", 32'(words_written), 5);

    // Reset mid-frame, then a clean restart
    hdr(8'h00, 16'd3);
    word(1'b0, 10'h000, 32'hCAFEF00D);
    send(8'h11);
    send(8'h22);
    do_reset();
    chk_reset("t6");
    hdr(8'h00, 16'd1);
    word(1'b0, 10'h000, 32'h44332211);
    idle(2);
    chk("t6_ww", 32'(words_written), 1);

    // Zero-length frame
    hdr(8'h01, 16'd0);
    idle(2);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_err", 32'(err), 0);
    chk("t7_ww", 32'(words_written), 1);

    idle(3);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
